// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store stage: access sizes, fault codes and FSM states.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_ALIGN = 2'b01,
        FLT_RANGE = 2'b10
    } flt_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// Picks the byte/half lane out of a little-endian word and sign- or zero-extends it.
module mem_access_unit_lane_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data     = 32'h0;
        case (size)
            SZ_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SZ_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            SZ_WORD: data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage in front of word-only dmem: sub-word loads/stores, RMW for
// sub-word stores, and sticky capture of the first misaligned/out-of-range access.
//
//   state     | meaning
//   ST_IDLE   | accept requests; loads and word stores complete this cycle
//   ST_RMW_WR | write back the merged word of a sub-word store
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_wdata,
    input  logic [AW-1:0] dmem_rd,
    output logic [AW-1:0] dmem_a,
    output logic [AW-1:0] dmem_wd,
    output logic          dmem_we,
    output logic [AW-1:0] load_data,
    output logic          stall,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic [AW-1:0] fault_addr
);

    state_t        state_q, state_d;
    logic [AW-1:0] rmw_addr_q, rmw_data_q;
    logic [AW-1:0] merged;
    logic [AW-1:0] lane_data;
    logic          misalign, out_of_range, req_fault, rmw_load;
    flt_t          fault_code_q;

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = req_addr[0];
            SZ_WORD: misalign = |req_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    assign out_of_range = req_addr[AW-1:2] >= (AW-2)'(MEM_WORDS);
    // Faults are only judged on requests actually sampled in IDLE
    assign req_fault = req_valid && (state_q == ST_IDLE) && (misalign || out_of_range);

    always_comb begin
        merged = dmem_rd;
        if (req_size == SZ_BYTE)
            merged[8*req_addr[1:0] +: 8] = req_wdata[7:0];
        else
            merged[16*req_addr[1] +: 16] = req_wdata[15:0];
    end

    mem_access_unit_lane_extract u_lane (
        .word        (dmem_rd),
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (lane_data)
    );

    assign load_data = (state_q == ST_IDLE && req_valid && !req_write && !req_fault)
                       ? lane_data : '0;

    always_comb begin
        state_d  = state_q;
        dmem_a   = {req_addr[AW-1:2], 2'b00};
        dmem_wd  = req_wdata;
        dmem_we  = 1'b0;
        stall    = 1'b0;
        rmw_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_write && !req_fault) begin
                    if (req_size == SZ_WORD) begin
                        dmem_we = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        rmw_load = 1'b1;
                        state_d  = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                dmem_a  = rmw_addr_q;
                dmem_wd = rmw_data_q;
                dmem_we = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset arriving mid-cycle must kill a pending write immediately
        if (reset) begin
            dmem_we = 1'b0;
            stall   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (rmw_load) begin
                rmw_addr_q <= {req_addr[AW-1:2], 2'b00};
                rmw_data_q <= merged;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault        <= 1'b0;
            fault_code_q <= FLT_NONE;
            fault_addr   <= '0;
        end else if (req_fault && !fault) begin
            fault        <= 1'b1;
            fault_code_q <= misalign ? FLT_ALIGN : FLT_RANGE;
            fault_addr   <= req_addr;
        end
    end

    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory behind it.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] dmem_rd, dmem_a, dmem_wd, load_data, fault_addr;
    logic        dmem_we, stall, fault;
    logic [1:0]  fault_code;
    logic        preload;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(64), .AW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dmem_rd      (dmem_rd),
        .dmem_a       (dmem_a),
        .dmem_wd      (dmem_wd),
        .dmem_we      (dmem_we),
        .load_data    (load_data),
        .stall        (stall),
        .fault        (fault),
        .fault_code   (fault_code),
        .fault_addr   (fault_addr)
    );

    assign dmem_rd = (dmem_a[31:2] < 30'd64) ? mem[dmem_a[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h8899AABB;
            mem[5] <= 32'hAAAAAAAA;
        end else if (dmem_we && dmem_a[31:2] < 30'd64) begin
            mem[dmem_a[7:2]] <= dmem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("rst_we", dmem_we, 0);
        check("rst_stall", stall, 0);
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_faddr", fault_addr, 0);
        tick;
        preload = 1'b0;
        check("rst_we2", dmem_we, 0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick;
        check("rst_nowrite", mem[4], 32'h0);

        // loads from word 2 = 0x8899AABB
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0);
        check("lb", load_data, 32'hFFFFFF88);
        check("lb_stall", stall, 0);
        check("lb_a", dmem_a, 32'h08);
        tick;
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0);
        check("lbu", load_data, 32'h00000088);
        tick;
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0);
        check("lh", load_data, 32'hFFFFAABB);
        tick;
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
        check("lhu", load_data, 32'h00008899);
        check("lhu_stall", stall, 0);
        tick;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        check("lw", load_data, 32'h8899AABB);
        check("lw_we", dmem_we, 0);
        tick;

        // idle with store-looking inputs
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        check("idle_we", dmem_we, 0);
        check("idle_ld", load_data, 0);
        tick;

        // word store
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        check("sw_we", dmem_we, 1);
        check("sw_a", dmem_a, 32'h10);
        check("sw_wd", dmem_wd, 32'h12345678);
        check("sw_stall", stall, 0);
        check("sw_ld", load_data, 0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("sw_mem", mem[4], 32'h12345678);

        // sb 0xEE -> 0x11
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000EE);
        check("sb_c1_stall", stall, 1);
        check("sb_c1_we", dmem_we, 0);
        tick;
        check("sb_c2_we", dmem_we, 1);
        check("sb_c2_wd", dmem_wd, 32'h1234EE78);
        check("sb_c2_a", dmem_a, 32'h10);
        check("sb_c2_stall", stall, 0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("sb_mem", mem[4], 32'h1234EE78);

        // sh 0xCAFE -> 0x12
        drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE);
        check("sh_c1_stall", stall, 1);
        tick;
        check("sh_c2_wd", dmem_wd, 32'hCAFEEE78);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("sh_mem", mem[4], 32'hCAFEEE78);

        // misaligned lw
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        check("mis_ld", load_data, 0);
        check("mis_stall", stall, 0);
        check("mis_fault_pre", fault, 0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("mis_fault", fault, 1);
        check("mis_code", fault_code, 2'b01);
        check("mis_faddr", fault_addr, 32'h06);

        // out-of-range store does not overwrite the first fault
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        check("oor_we", dmem_we, 0);
        check("oor_stall", stall, 0);
        tick;
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF);
        check("sz11_we", dmem_we, 0);
        check("sz11_stall", stall, 0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("oor_code_hold", fault_code, 2'b01);
        check("oor_faddr_hold", fault_addr, 32'h06);
        check("sz11_mem", mem[8], 32'h0);

        // reset then out-of-range
        reset = 1'b1;
        #1;
        check("rst2_fault", fault, 0);
        tick;
        reset = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        check("oor2_we", dmem_we, 0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("oor2_fault", fault, 1);
        check("oor2_code", fault_code, 2'b10);
        check("oor2_faddr", fault_addr, 32'h100);

        // reset during RMW_WR aborts the write
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h14, 32'h00000055);
        check("abort_c1_stall", stall, 1);
        tick;
        check("abort_c2_we_pre", dmem_we, 1);
        reset = 1'b1;
        #1;
        check("abort_we", dmem_we, 0);
        check("abort_stall", stall, 0);
        tick;
        check("abort_mem", mem[5], 32'hAAAAAAAA);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick;
        check("abort_idle_we", dmem_we, 0);
        check("abort_mem2", mem[5], 32'hAAAAAAAA);

        // back-to-back sb 0x01..0x04 into word 8
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h20 + i, 32'(i + 1));
            check("b2b_c1_stall", stall, 1);
            check("b2b_c1_we", dmem_we, 0);
            tick;
            check("b2b_c2_we", dmem_we, 1);
            check("b2b_c2_stall", stall, 0);
            tick;
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        check("b2b_mem", mem[8], 32'h04030201);
        check("b2b_we_after", dmem_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
